// File: rtl/cmsdk_fpga_sram_arb.sv
// Two-port round-robin arbiter with bounded lock, sharing one single-port byte-write block RAM.
// Latency: grant is combinational in the request cycle; read data returns one cycle after the grant.
// Backpressure: a losing requester holds REQ and its fields until GNT; every cycle grants at most one access.
module cmsdk_fpga_sram_arb #(
  parameter int AW       = 16,
  parameter int MAX_LOCK = 16
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          P0_REQ,
  input  logic          P0_WRITE,
  input  logic          P0_LOCK,
  input  logic [AW-1:0] P0_ADDR,
  input  logic [31:0]   P0_WDATA,
  input  logic [3:0]    P0_WSTRB,
  output logic          P0_GNT,
  output logic          P0_RVALID,
  output logic [31:0]   P0_RDATA,
  input  logic          P1_REQ,
  input  logic          P1_WRITE,
  input  logic          P1_LOCK,
  input  logic [AW-1:0] P1_ADDR,
  input  logic [31:0]   P1_WDATA,
  input  logic [3:0]    P1_WSTRB,
  output logic          P1_GNT,
  output logic          P1_RVALID,
  output logic [31:0]   P1_RDATA,
  output logic [AW-1:0] SRAM_ADDR,
  output logic [31:0]   SRAM_WDATA,
  output logic [3:0]    SRAM_WREN,
  output logic          SRAM_CS,
  input  logic [31:0]   SRAM_RDATA
);

  // With MAX_LOCK = 0 the counter keeps one bit but the limit is 0, so locking never wins.
  localparam int             LCW        = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;
  localparam logic [LCW-1:0] LOCK_LIMIT = LCW'(MAX_LOCK);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // Arbitration state: most recent owner, whether it asked to keep the RAM, and the lock streak.
  port_e          last_gnt;
  port_e          last_gnt_nxt;
  logic           last_lock;
  logic           last_lock_nxt;
  logic [LCW-1:0] lock_cnt;
  logic [LCW-1:0] lock_cnt_nxt;
  logic [1:0]     rd_pend;
  logic [1:0]     rd_pend_nxt;

  logic           both_req;
  logic           owner_holds;
  logic           any_gnt;
  port_e          win;

  logic           win_write;
  logic           win_lock;
  logic [AW-1:0]  win_addr;
  logic [31:0]    win_wdata;
  logic [3:0]     win_wstrb;

  assign both_req    = P0_REQ & P1_REQ;
  // The owner may keep the RAM only under contention, only if it locked last time, and only up to the limit.
  assign owner_holds = both_req & last_lock & (lock_cnt < LOCK_LIMIT);

  // Winner selection; nothing is granted while reset is held low.
  always_comb begin
    any_gnt = 1'b0;
    win     = PORT0;
    if (RESETn) begin
      if (both_req) begin
        any_gnt = 1'b1;
        win     = owner_holds ? last_gnt : port_e'(~last_gnt);
      end else if (P0_REQ) begin
        any_gnt = 1'b1;
        win     = PORT0;
      end else if (P1_REQ) begin
        any_gnt = 1'b1;
        win     = PORT1;
      end
    end
  end

  // Steer the winner's request fields; with no winner P0's fields pass through as don't-care.
  always_comb begin
    win_write = P0_WRITE;
    win_lock  = P0_LOCK;
    win_addr  = P0_ADDR;
    win_wdata = P0_WDATA;
    win_wstrb = P0_WSTRB;
    if (win == PORT1) begin
      win_write = P1_WRITE;
      win_lock  = P1_LOCK;
      win_addr  = P1_ADDR;
      win_wdata = P1_WDATA;
      win_wstrb = P1_WSTRB;
    end
  end

  // Next arbitration state and read-return tracking.
  always_comb begin
    last_gnt_nxt  = last_gnt;
    last_lock_nxt = last_lock;
    lock_cnt_nxt  = '0;
    rd_pend_nxt   = 2'b00;
    if (any_gnt) begin
      last_gnt_nxt  = win;
      last_lock_nxt = win_lock;
      if (owner_holds) begin
        lock_cnt_nxt = lock_cnt + 1'b1;
      end
      if (!win_write) begin
        if (win == PORT1) begin
          rd_pend_nxt[1] = 1'b1;
        end else begin
          rd_pend_nxt[0] = 1'b1;
        end
      end
    end
  end

  // State registers; reset makes P0 win the first tie and drops any read in flight.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      last_gnt  <= PORT1;
      last_lock <= 1'b0;
      lock_cnt  <= '0;
      rd_pend   <= 2'b00;
    end else begin
      last_gnt  <= last_gnt_nxt;
      last_lock <= last_lock_nxt;
      lock_cnt  <= lock_cnt_nxt;
      rd_pend   <= rd_pend_nxt;
    end
  end

  assign P0_GNT     = any_gnt & (win == PORT0);
  assign P1_GNT     = any_gnt & (win == PORT1);

  // A write with all strobes clear still selects the RAM but changes nothing.
  assign SRAM_CS    = any_gnt;
  assign SRAM_WREN  = (any_gnt && win_write) ? win_wstrb : 4'h0;
  assign SRAM_ADDR  = win_addr;
  assign SRAM_WDATA = win_wdata;

  // Read data is only steered to the port that issued the read; a reset cycle hides it.
  assign P0_RVALID  = rd_pend[0] & RESETn;
  assign P1_RVALID  = rd_pend[1] & RESETn;
  assign P0_RDATA   = P0_RVALID ? SRAM_RDATA : 32'h0;
  assign P1_RDATA   = P1_RVALID ? SRAM_RDATA : 32'h0;

endmodule
